// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microcoded CPU sequencer: control-bit indices,
// opcode encodings, the state enumeration and a per-opcode step-count helper.
package cpu_ctrl_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned ST_W   = 4;

  localparam int unsigned C_PC_TO_MAR  = 0;
  localparam int unsigned C_MEM_TO_MBR = 1;
  localparam int unsigned C_MBR_TO_IR  = 2;
  localparam int unsigned C_PC_INC     = 3;
  localparam int unsigned C_IR_TO_MAR  = 4;
  localparam int unsigned C_MBR_TO_MEM = 5;
  localparam int unsigned C_ACC_TO_MBR = 6;
  localparam int unsigned C_IR_TO_PC   = 7;
  localparam int unsigned C_MBR_TO_BR  = 8;
  localparam int unsigned C_ACC_CLR    = 9;
  localparam int unsigned C_ACC_ADD    = 10;
  localparam int unsigned C_ACC_SUB    = 11;
  localparam int unsigned C_ACC_AND    = 12;
  localparam int unsigned C_ACC_OR     = 13;
  localparam int unsigned C_ACC_NOT    = 14;
  localparam int unsigned C_ACC_LOAD   = 15;

  localparam logic [OP_W-1:0] OP_STORE  = 8'h01;
  localparam logic [OP_W-1:0] OP_LOAD   = 8'h02;
  localparam logic [OP_W-1:0] OP_ADD    = 8'h03;
  localparam logic [OP_W-1:0] OP_SUB    = 8'h04;
  localparam logic [OP_W-1:0] OP_JMPGEZ = 8'h05;
  localparam logic [OP_W-1:0] OP_JMP    = 8'h06;
  localparam logic [OP_W-1:0] OP_HALT   = 8'h07;
  localparam logic [OP_W-1:0] OP_AND    = 8'h08;
  localparam logic [OP_W-1:0] OP_OR     = 8'h09;
  localparam logic [OP_W-1:0] OP_NOT    = 8'h0A;

  // EXEC1..EXEC4 must stay consecutive; the sequencer advances by increment.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH1  = 4'd1,
    ST_FETCH2  = 4'd2,
    ST_FETCH3  = 4'd3,
    ST_DECODE  = 4'd4,
    ST_EXEC1   = 4'd5,
    ST_EXEC2   = 4'd6,
    ST_EXEC3   = 4'd7,
    ST_EXEC4   = 4'd8,
    ST_HALTED  = 4'd9
  } state_e;

  // Final execute state of an opcode; the step after it returns to FETCH1.
  function automatic state_e last_exec(input logic [OP_W-1:0] op);
    state_e last;
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: last = ST_EXEC4;
      OP_STORE:                               last = ST_EXEC3;
      default:                                last = ST_EXEC1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational control-word decoder: maps the current sequencer state and
// latched opcode to the sixteen datapath strobes.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e            state,
  input  logic [OP_W-1:0]   op_reg,
  input  logic              acc_neg,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      ST_FETCH1: ctrl_c[C_PC_TO_MAR] = 1'b1;
      ST_FETCH2: begin
        ctrl_c[C_MEM_TO_MBR] = 1'b1;
        // PC bumps only on the completing read cycle, never during a stall.
        ctrl_c[C_PC_INC]     = mem_ready;
      end
      ST_FETCH3: ctrl_c[C_MBR_TO_IR] = 1'b1;
      ST_EXEC1: begin
        case (op_reg)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STORE:
            ctrl_c[C_IR_TO_MAR] = 1'b1;
          OP_JMP:    ctrl_c[C_IR_TO_PC] = 1'b1;
          OP_JMPGEZ: ctrl_c[C_IR_TO_PC] = ~acc_neg;
          OP_NOT:    ctrl_c[C_ACC_NOT]  = 1'b1;
          default:   ctrl_c = '0;
        endcase
      end
      ST_EXEC2: begin
        case (op_reg)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR:
            ctrl_c[C_MEM_TO_MBR] = 1'b1;
          OP_STORE: ctrl_c[C_ACC_TO_MBR] = 1'b1;
          default:  ctrl_c = '0;
        endcase
      end
      ST_EXEC3: begin
        case (op_reg)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR:
            ctrl_c[C_MBR_TO_BR] = 1'b1;
          OP_STORE: ctrl_c[C_MBR_TO_MEM] = 1'b1;
          default:  ctrl_c = '0;
        endcase
      end
      ST_EXEC4: begin
        case (op_reg)
          OP_LOAD: ctrl_c[C_ACC_LOAD] = 1'b1;
          OP_ADD:  ctrl_c[C_ACC_ADD]  = 1'b1;
          OP_SUB:  ctrl_c[C_ACC_SUB]  = 1'b1;
          OP_AND:  ctrl_c[C_ACC_AND]  = 1'b1;
          OP_OR:   ctrl_c[C_ACC_OR]   = 1'b1;
          default: ctrl_c = '0;
        endcase
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control sequencer: state register, opcode latch and
// next-state logic, with memory-ready stalls on read/write steps.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   ir_opcode,
  input  logic              acc_neg,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] control_signals,
  output logic              busy,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_reg_q, op_reg_d;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              mem_stall;

  cpu_ctrl_decode u_decode (
    .state     (state_q),
    .op_reg    (op_reg_q),
    .acc_neg   (acc_neg),
    .mem_ready (mem_ready),
    .ctrl_c    (dec_ctrl)
  );

  // Any memory read or write step holds until the memory acknowledges.
  assign mem_stall = (dec_ctrl[C_MEM_TO_MBR] | dec_ctrl[C_MBR_TO_MEM]) & ~mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_reg_q <= '0;
    end else begin
      state_q  <= state_d;
      op_reg_q <= op_reg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_reg_d = op_reg_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH1;
      ST_FETCH1: state_d = ST_FETCH2;
      ST_FETCH2: if (!mem_stall) state_d = ST_FETCH3;
      ST_FETCH3: state_d = ST_DECODE;
      ST_DECODE: begin
        op_reg_d = ir_opcode;
        state_d  = (ir_opcode == OP_HALT) ? ST_HALTED : ST_EXEC1;
      end
      ST_EXEC1, ST_EXEC2, ST_EXEC3, ST_EXEC4: begin
        if (!mem_stall) begin
          if (state_q == last_exec(op_reg_q)) state_d = ST_FETCH1;
          else                                state_d = state_e'(state_q + ST_W'(1));
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low for as long as reset is held.
  always_comb begin
    control_signals = '0;
    busy            = 1'b0;
    halted          = 1'b0;
    if (rst_n) begin
      control_signals = dec_ctrl;
      if (state_q == ST_IDLE && start) control_signals[C_ACC_CLR] = 1'b1;
      busy   = (state_q != ST_IDLE) && (state_q != ST_HALTED);
      halted = (state_q == ST_HALTED);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  ir_opcode;
  logic        acc_neg;
  logic        mem_ready;
  logic [15:0] control_signals;
  logic        busy;
  logic        halted;

  typedef struct {
    logic [15:0] ctrl;
    logic        busy;
    logic        halted;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total   = 0;
  int   bad     = 0;
  int   step_id = 0;

  cpu_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .ir_opcode       (ir_opcode),
    .acc_neg         (acc_neg),
    .mem_ready       (mem_ready),
    .control_signals (control_signals),
    .busy            (busy),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs and record what that cycle must show.
  task automatic step(input logic rst_v, input logic st, input logic [7:0] op,
                      input logic neg, input logic mr, input logic [15:0] ec,
                      input logic eb, input logic eh);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst_v;
    start     = st;
    ir_opcode = op;
    acc_neg   = neg;
    mem_ready = mr;
    e.ctrl    = ec;
    e.busy    = eb;
    e.halted  = eh;
    e.id      = step_id;
    step_id++;
    sb_q.push_back(e);
  endtask

  task automatic run(input logic mr, input logic [15:0] ec);
    step(1'b1, 1'b0, 8'h00, 1'b0, mr, ec, 1'b1, 1'b0);
  endtask

  task automatic fetch(input int stalls);
    run(1'b1, 16'h0001);
    for (int i = 0; i < stalls; i++) run(1'b0, 16'h0002);
    run(1'b1, 16'h000A);
    run(1'b1, 16'h0004);
  endtask

  task automatic decode(input logic [7:0] op);
    step(1'b1, 1'b0, op, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total++;
      if ({control_signals, busy, halted} !== {mon_e.ctrl, mon_e.busy, mon_e.halted}) begin
        bad++;
        $display("FAIL step %0d: got ctrl=%h busy=%b halted=%b, expected ctrl=%h busy=%b halted=%b",
                 mon_e.id, control_signals, busy, halted, mon_e.ctrl, mon_e.busy, mon_e.halted);
      end
    end
  end

  logic [7:0]  alu_op  [3];
  logic [15:0] alu_res [3];

  initial begin
    rst_n = 1'b0; start = 1'b0; ir_opcode = 8'h00; acc_neg = 1'b0; mem_ready = 1'b1;
    alu_op[0] = 8'h04; alu_res[0] = 16'h0800;
    alu_op[1] = 8'h08; alu_res[1] = 16'h1000;
    alu_op[2] = 8'h09; alu_res[2] = 16'h2000;

    // Reset state, including start asserted while reset is held
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);

    // LOAD trace
    fetch(0); decode(8'h02);
    run(1'b1, 16'h0010); run(1'b1, 16'h0002); run(1'b1, 16'h0100); run(1'b1, 16'h8000);

    // JMPGEZ with negative then non-negative accumulator
    fetch(0); decode(8'h05);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    fetch(0); decode(8'h05);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0080, 1'b1, 1'b0);

    // STORE with a three-cycle write stall
    fetch(0); decode(8'h01);
    run(1'b1, 16'h0010); run(1'b1, 16'h0040);
    run(1'b0, 16'h0020); run(1'b0, 16'h0020); run(1'b0, 16'h0020); run(1'b1, 16'h0020);

    // Instruction read stalled two cycles, then NOT
    fetch(2); decode(8'h0A);
    run(1'b1, 16'h4000);

    // ADD with a one-cycle operand read stall
    fetch(0); decode(8'h03);
    run(1'b1, 16'h0010); run(1'b0, 16'h0002); run(1'b1, 16'h0002);
    run(1'b1, 16'h0100); run(1'b1, 16'h0400);

    // SUB / AND / OR
    for (int k = 0; k < 3; k++) begin
      fetch(0); decode(alu_op[k]);
      run(1'b1, 16'h0010); run(1'b1, 16'h0002); run(1'b1, 16'h0100); run(1'b1, alu_res[k]);
    end

    // Unknown opcode acts as NOP; then JMP
    fetch(0); decode(8'hFF); run(1'b1, 16'h0000);
    fetch(0); decode(8'h06); run(1'b1, 16'h0080);

    // Reset asserted during a stalled EXEC2 of ADD
    fetch(0); decode(8'h03);
    run(1'b1, 16'h0010);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);

    // HALT: sticky until reset, start ignored
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    fetch(0); decode(8'h07);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    run(1'b1, 16'h0001);

    repeat (4) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
